// File: rtl/sat_pkg.sv
// Shared definitions for the saturating adder and block accumulator.
package sat_pkg;

  localparam int unsigned HELPER_W  = 64;
  localparam int unsigned HELPER_IW = 6;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Largest positive W-bit two's-complement value, zero-extended to HELPER_W.
  function automatic logic [HELPER_W-1:0] sat_max(input int unsigned w);
    return (HELPER_W'(1) << (w - 1)) - HELPER_W'(1);
  endfunction

  // Most negative W-bit two's-complement value; truncate to W bits at the use site.
  function automatic logic [HELPER_W-1:0] sat_min(input int unsigned w);
    return HELPER_W'(1) << (w - 1);
  endfunction

  // Sign-extend the low w bits of x to HELPER_W bits.
  function automatic logic [HELPER_W-1:0] sext(input logic [HELPER_W-1:0] x,
                                               input int unsigned w);
    logic [HELPER_W-1:0] hi_mask;
    hi_mask = ~HELPER_W'(0) << w;
    return x[HELPER_IW'(w - 1)] ? (x | hi_mask) : (x & ~hi_mask);
  endfunction

endpackage

// File: rtl/sat_add_w.sv
// Combinational W-bit two's-complement adder that clamps to the rails on overflow.
module sat_add_w
  import sat_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_c_o,
  output logic         ov_c_o
);

  logic [W-1:0] raw;

  // Overflow only when both operands share a sign the raw sum does not.
  always_comb begin
    raw     = a_i + b_i;
    ov_c_o  = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
    sum_c_o = raw;
    if (ov_c_o) begin
      sum_c_o = a_i[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
    end
  end

endmodule

// File: rtl/sat_block_accum.sv
// Block accumulator: sums LEN saturating samples per block and emits one result.
// Optional build macro SAT_BLOCK_ACCUM_AVG_EN: full blocks report the average.
module sat_block_accum
  import sat_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_ov,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_cnt
);

`ifdef SAT_BLOCK_ACCUM_AVG_EN
  localparam int unsigned LOG2_LEN = $clog2(LEN);
  if ((LEN & (LEN - 1)) != 0) begin : g_len_check
    $error("LEN must be a power of two when averaging is enabled");
  end
`endif

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_ov;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] acc_fin;
  logic             sat_fin;
  logic [CNT_W-1:0] cnt_fin;
  logic             full;

  assign add_b = ACC_W'(sext(HELPER_W'(in_data), N));

  sat_add_w #(.W(ACC_W)) u_add (
    .a_i     (acc_q),
    .b_i     (add_b),
    .sum_c_o (add_sum),
    .ov_c_o  (add_ov)
  );

  // Values the block would hold after this cycle's sample, if any.
  always_comb begin
    accept  = in_valid && in_ready_q && (state_q == ST_ACCUM);
    cnt_inc = CNT_W'(cnt_q + CNT_W'(1));
    acc_fin = accept ? add_sum : acc_q;
    sat_fin = sat_q | (accept & (in_ov | add_ov));
    cnt_fin = accept ? cnt_inc : cnt_q;
    full    = accept && (cnt_inc == CNT_W'(LEN));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_cnt_d   = out_cnt_q;
    case (state_q)
      ST_ACCUM: begin
        acc_d = acc_fin;
        cnt_d = cnt_fin;
        sat_d = sat_fin;
        if (full || (flush && ((cnt_q != '0) || accept))) begin
          state_d     = ST_HOLD;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_sat_d   = sat_fin;
          out_cnt_d   = cnt_fin;
`ifdef SAT_BLOCK_ACCUM_AVG_EN
          out_data_d  = full ? ACC_W'($signed(acc_fin) >>> LOG2_LEN) : acc_fin;
`else
          out_data_d  = acc_fin;
`endif
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_ACCUM;
          acc_d       = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: doc/sat_block_accum.md
Name: sat_block_accum

Overview:
- Downstream consumer of the saturating two's-complement adder stage.
- Takes a valid/ready stream of N-bit signed sums and their overflow flags.
- Accumulates LEN samples per block into an ACC_W-bit saturating accumulator.
- Emits one block result per block, with a sticky saturation flag and a sample count, over a valid/ready output.

Parameters:
- N, 4, input sample width (signed two's complement); matches the upstream adder width.
- ACC_W, 8, accumulator/output width; must satisfy ACC_W >= N.
- LEN, 4, samples per block; LEN >= 1.
- CNT_W, $clog2(LEN+1), width of sample count.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  N  signed sample
- in_ov  in  1  upstream overflow/saturation flag for this sample
- flush  in  1  close current partial block
- out_valid  out  1  block result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed block sum (or average, see feature)
- out_sat  out  1  any saturation in block (upstream or local)
- out_cnt  out  CNT_W  samples contained in block

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at clk edge; overrides everything, including mid-block or mid-hold):
  - State goes to ACCUM; acc=0, cnt=0, sat=0.
  - out_valid=0, out_data=0, out_sat=0, out_cnt=0.
  - in_ready=1 from the first cycle after reset.
- FSM states: ACCUM, HOLD.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - Accept on in_valid&&in_ready.
  - acc <= sat_add(acc, sext(in_data)); cnt <= cnt+1; sat <= sat | in_ov | local_ov.
- Saturating add:
  - Overflow when both operands have the same sign and the raw sum's sign differs.
  - Clamp to MAX={0,1..1} if operand sign is 0, else MIN={1,0..0}.
  - Once at a rail, further adds stay saturated or move back normally; no wrap-around ever.
- ACCUM -> HOLD, on either:
  - an accepted sample that makes cnt==LEN, or
  - flush=1 with (cnt>0 or a sample accepted that cycle).
- Simultaneous flush and accepted sample: the sample is included, then HOLD.
- flush with cnt==0 and no sample: ignored, no empty block emitted.
- HOLD state:
  - out_valid=1, in_ready=0.
  - out_data, out_sat and out_cnt are registered and stable until the handshake.
  - flush is ignored.
  - On out_valid&&out_ready: clear acc/cnt/sat, return to ACCUM; in_ready=1 the next cycle.
- Latency: result visible one cycle after the last accepted sample.
- Throughput: LEN+1 cycles per block minimum (one bubble for the output handshake).
- out_data/out_sat/out_cnt in ACCUM hold the last emitted value (0 after reset); they are meaningful only while out_valid=1.

Optional Feature:
- Macro: SAT_BLOCK_ACCUM_AVG_EN.
- Defined:
  - LEN must be a power of two (elaboration check).
  - Full blocks: out_data = acc >>> log2(LEN) (arithmetic shift, truncation toward -inf).
  - Flushed partial blocks: raw sum, out_cnt tells the consumer.
- Undefined: out_data is always the raw saturated sum.

Decomposition:
- Shared package/header sat_pkg holds:
  - state encoding constants ST_ACCUM=0, ST_HOLD=1;
  - sat_max(W)/sat_min(W) constant helpers;
  - sign-extension helper.
- One sub-module: sat_add_w, a combinational W-bit saturating adder producing sum and ov. It reuses the upstream clamping rule and is instantiated once with W=ACC_W.

Test Plan:
- Plain sum: N=4, ACC_W=8, LEN=4; inputs 1,2,3,4 back-to-back, out_ready=1 -> out_data=0x0A, out_sat=0, out_cnt=4, out_valid for 1 cycle, one cycle after the 4th accept.
- Negative extension: inputs 0x8 (-8) x4 -> out_data=0xE0 (-32), out_sat=0.
- Local saturation: ACC_W=5 instance; inputs 7,7,7,7 -> out_data=0x0F (+15), out_sat=1. Repeat with 0x8 x4 -> 0x10 (-16), out_sat=1.
- Upstream flag and backpressure:
  - Inputs 1,1,1,1 with in_ov=1 on sample 2 -> out_sat=1, out_data=4.
  - Hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout; then out_ready=1 -> in_ready=1 the next cycle.
- Flush and edge cases:
  - Samples 3, 0xF(-1), then flush -> out_data=2, out_cnt=2.
  - flush at cnt=0 -> no out_valid.
  - flush together with a sample -> that sample is included.
- Reset mid-block after 2 samples -> cnt=0, no output. The next 4 samples 1,1,1,1 -> out_data=4. With SAT_BLOCK_ACCUM_AVG_EN, inputs 1,2,3,4 -> out_data=2.
